// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl_if
// Brief    : Source, CSR and trap-handshake bundle between the CSR unit and
//            the machine-level interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
interface irq_ctrl_if #(
  parameter int NUM_LOCAL = 4
);
  logic                 ext_irq;
  logic                 timer_irq;
  logic [NUM_LOCAL-1:0] local_irq;
  logic [31:0]          mip_in;
  logic                 wr_mip;
  logic [31:0]          mie_in;
  logic                 wr_mie;
  logic                 mstatus_mie;
  logic                 mret;
  logic                 trap_ack;
  logic [31:0]          mip;
  logic [31:0]          mie;
  logic                 trap_req;
  logic [31:0]          trap_cause;

  modport master (
    output ext_irq, timer_irq, local_irq, mip_in, wr_mip, mie_in, wr_mie,
           mstatus_mie, mret, trap_ack,
    input  mip, mie, trap_req, trap_cause
  );

  modport slave (
    input  ext_irq, timer_irq, local_irq, mip_in, wr_mip, mie_in, wr_mie,
           mstatus_mie, mret, trap_ack,
    output mip, mie, trap_req, trap_cause
  );
endinterface
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Brief    : Machine-level interrupt controller owning MIP/MIE, with local
//            platform interrupts, fixed-priority arbitration and trap handshake.
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
  parameter int                   NUM_LOCAL   = 4,
  parameter logic [NUM_LOCAL-1:0] LOCAL_EDGE  = '0,
  parameter int                   SYNC_STAGES = 2
) (
  input  wire logic   clk,
  input  wire logic   rst,
  irq_ctrl_if.slave   bus
);

  localparam int          c_NSRC     = NUM_LOCAL + 2;
  localparam logic [31:0] c_LOC_ONES = {{(32-NUM_LOCAL){1'b0}}, {NUM_LOCAL{1'b1}}};
  localparam logic [31:0] c_MIE_MASK = 32'h0000_0888 | (c_LOC_ONES << 16);

  localparam logic [1:0]  c_IDLE    = 2'd0;
  localparam logic [1:0]  c_REQ     = 2'd1;
  localparam logic [1:0]  c_SERVICE = 2'd2;

  logic [c_NSRC-1:0]    w_src;
  logic [c_NSRC-1:0]    w_sync;
  logic [NUM_LOCAL-1:0] w_mip_loc;
  logic [NUM_LOCAL-1:0] w_ack_clr;
  logic [31:0]          w_mip;
  logic [31:0]          w_act;
  logic                 w_any;
  logic [4:0]           w_code;
  logic                 w_take;
  logic                 w_unused;

  logic                 r_meip;
  logic                 r_mtip;
  logic                 r_msip;
  logic [31:0]          r_mie;
  logic [1:0]           r_state;
  logic [4:0]           r_code;

  // Source vector layout: {local[N-1:0], timer, ext}
  assign w_src    = {bus.local_irq, bus.timer_irq, bus.ext_irq};
  assign w_unused = &{1'b0, bus.mip_in};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_sync = w_src;
    end else begin : g_sync
      logic [c_NSRC-1:0] r_chain [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < SYNC_STAGES; s++) r_chain[s] <= '0;
        end else begin
          r_chain[0] <= w_src;
          for (int s = 1; s < SYNC_STAGES; s++) r_chain[s] <= r_chain[s-1];
        end
      end
      assign w_sync = r_chain[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meip <= 1'b0;
      r_mtip <= 1'b0;
      r_msip <= 1'b0;
      r_mie  <= '0;
    end else begin
      r_meip <= w_sync[0];
      r_mtip <= w_sync[1];
      if (bus.wr_mip) r_msip <= bus.mip_in[3];
      if (bus.wr_mie) r_mie  <= bus.mie_in & c_MIE_MASK;
    end
  end

  assign w_take = (r_state == c_REQ) && bus.trap_ack;

  generate
    for (genvar i = 0; i < NUM_LOCAL; i++) begin : g_local
      assign w_ack_clr[i] = w_take && (r_code == 5'(16 + i));
      if (LOCAL_EDGE[i]) begin : g_edge
        logic r_prev;
        logic r_pend;
        always_ff @(posedge clk) begin
          if (rst) begin
            r_prev <= 1'b0;
            r_pend <= 1'b0;
          end else begin
            r_prev <= w_sync[2+i];
            // A new edge outranks a coincident software or ack clear
            if (w_sync[2+i] && !r_prev)
              r_pend <= 1'b1;
            else if ((bus.wr_mip && !bus.mip_in[16+i]) || w_ack_clr[i])
              r_pend <= 1'b0;
          end
        end
        assign w_mip_loc[i] = r_pend;
      end else begin : g_level
        logic r_lvl;
        always_ff @(posedge clk) begin
          if (rst) r_lvl <= 1'b0;
          else     r_lvl <= w_sync[2+i];
        end
        assign w_mip_loc[i] = r_lvl;
      end
    end
  endgenerate

  always_comb begin
    w_mip                   = '0;
    w_mip[11]               = r_meip;
    w_mip[7]                = r_mtip;
    w_mip[3]                = r_msip;
    w_mip[16 +: NUM_LOCAL]  = w_mip_loc;
  end

  assign w_act = bus.mstatus_mie ? (w_mip & r_mie) : '0;
  assign w_any = |w_act;

  // Later assignments win: lowest priority first, MEI last
  always_comb begin
    w_code = 5'd0;
    for (int i = 0; i < NUM_LOCAL; i++) begin
      if (w_act[16+i]) w_code = 5'(16 + i);
    end
    if (w_act[7])  w_code = 5'd7;
    if (w_act[3])  w_code = 5'd3;
    if (w_act[11]) w_code = 5'd11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_code  <= 5'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any) begin
            r_code  <= w_code;
            r_state <= c_REQ;
          end
        end
        c_REQ: begin
          if (bus.trap_ack)  r_state <= c_SERVICE;
          else if (!w_any)   r_state <= c_IDLE;
        end
        c_SERVICE: begin
          if (bus.mret) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.mip        = w_mip;
  assign bus.mie        = r_mie;
  assign bus.trap_req   = (r_state == c_REQ);
  assign bus.trap_cause = (r_state == c_IDLE) ? 32'd0 : {1'b1, 26'd0, r_code};

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl
// Brief    : Directed self-checking bench for irq_ctrl (4 locals, local 0 edge).
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  irq_ctrl_if #(.NUM_LOCAL(4)) bus ();

  irq_ctrl #(
    .NUM_LOCAL   (4),
    .LOCAL_EDGE  (4'b0001),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.ext_irq = 1'b1; bus.timer_irq = 1'b1; bus.local_irq = 4'hF;
    bus.mip_in = '0; bus.wr_mip = 1'b0; bus.mie_in = '0; bus.wr_mie = 1'b0;
    bus.mstatus_mie = 1'b0; bus.mret = 1'b0; bus.trap_ack = 1'b0;

    // Reset with sources high
    tick(2);
    check("rst_mip",   bus.mip,        32'h0);
    check("rst_mie",   bus.mie,        32'h0);
    check("rst_req",   {31'd0, bus.trap_req}, 32'h0);
    check("rst_cause", bus.trap_cause, 32'h0);
    rst = 1'b0;
    bus.ext_irq = 1'b0; bus.timer_irq = 1'b0; bus.local_irq = 4'h0;
    tick(4);
    check("idle_mip", bus.mip, 32'h0);

    // CSR write masking
    bus.wr_mip = 1'b1; bus.mip_in = 32'hFFFF_FFFF;
    tick();
    bus.wr_mip = 1'b0;
    check("mip_mask", bus.mip, 32'h0000_0008);
    bus.wr_mie = 1'b1; bus.mie_in = 32'hFFFF_FFFF;
    tick();
    bus.wr_mie = 1'b0;
    check("mie_mask", bus.mie, 32'h000F_0888);
    bus.wr_mip = 1'b1; bus.mip_in = 32'h0;
    bus.wr_mie = 1'b1; bus.mie_in = 32'h80;
    tick();
    bus.wr_mip = 1'b0; bus.wr_mie = 1'b0;
    check("msip_clr", bus.mip, 32'h0);
    check("mie_80",   bus.mie, 32'h80);

    // Level timer latency
    bus.mstatus_mie = 1'b1;
    bus.timer_irq   = 1'b1;
    tick(2);
    check("tmr_c2_mip", bus.mip, 32'h0);
    tick();
    check("tmr_c3_mip", bus.mip, 32'h80);
    check("tmr_c3_req", {31'd0, bus.trap_req}, 32'h0);
    tick();
    check("tmr_c4_req",   {31'd0, bus.trap_req}, 32'h1);
    check("tmr_c4_cause", bus.trap_cause, 32'h8000_0007);

    // Withdrawal and re-request
    bus.mstatus_mie = 1'b0;
    tick();
    check("wd_req",   {31'd0, bus.trap_req}, 32'h0);
    check("wd_cause", bus.trap_cause, 32'h0);
    bus.mstatus_mie = 1'b1;
    tick();
    check("wd_rereq",   {31'd0, bus.trap_req}, 32'h1);
    check("wd_recause", bus.trap_cause, 32'h8000_0007);

    bus.trap_ack = 1'b1;
    tick();
    bus.trap_ack = 1'b0;
    check("tmr_ack_req",   {31'd0, bus.trap_req}, 32'h0);
    check("tmr_svc_cause", bus.trap_cause, 32'h8000_0007);
    bus.timer_irq = 1'b0;
    tick(4);
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    tick(2);
    check("tmr_done_req", {31'd0, bus.trap_req}, 32'h0);

    // Priority: MEI over MTI over local 2
    bus.wr_mie = 1'b1; bus.mie_in = 32'h0004_0880;
    bus.ext_irq = 1'b1; bus.timer_irq = 1'b1; bus.local_irq = 4'b0100;
    tick();
    bus.wr_mie = 1'b0;
    tick(4);
    check("pri_mip",   bus.mip,        32'h0004_0880);
    check("pri_cause", bus.trap_cause, 32'h8000_000B);
    bus.trap_ack = 1'b1;
    tick();
    bus.trap_ack = 1'b0;
    bus.ext_irq  = 1'b0;
    tick(3);
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    check("pri_idle_req", {31'd0, bus.trap_req}, 32'h0);
    tick();
    check("pri2_req",   {31'd0, bus.trap_req}, 32'h1);
    check("pri2_cause", bus.trap_cause, 32'h8000_0007);

    // ack and mret together in REQ: ack only, stays in service
    bus.trap_ack = 1'b1; bus.mret = 1'b1;
    tick();
    bus.trap_ack = 1'b0; bus.mret = 1'b0;
    tick(2);
    check("ackmret_req",   {31'd0, bus.trap_req}, 32'h0);
    check("ackmret_cause", bus.trap_cause, 32'h8000_0007);
    bus.timer_irq = 1'b0;
    tick(3);
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    tick();
    check("loc2_cause", bus.trap_cause, 32'h8000_0012);
    bus.trap_ack = 1'b1;
    tick();
    bus.trap_ack = 1'b0;
    bus.local_irq = 4'b0000;
    tick(4);
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    tick();
    check("loc2_done_req", {31'd0, bus.trap_req}, 32'h0);

    // Edge local 0: pulse latches, ack auto-clears
    bus.wr_mie = 1'b1; bus.mie_in = 32'h0001_0000;
    tick();
    bus.wr_mie = 1'b0;
    bus.local_irq = 4'b0001;
    tick();
    bus.local_irq = 4'b0000;
    tick(4);
    check("edge_mip",   bus.mip,        32'h0001_0000);
    check("edge_cause", bus.trap_cause, 32'h8000_0010);
    bus.trap_ack = 1'b1;
    tick();
    bus.trap_ack = 1'b0;
    check("edge_autoclr", bus.mip, 32'h0);
    check("edge_ack_req", {31'd0, bus.trap_req}, 32'h0);
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    tick();
    check("edge_noreq", {31'd0, bus.trap_req}, 32'h0);

    // Edge set beats a coincident software clear
    bus.mstatus_mie = 1'b0;
    bus.local_irq = 4'b0001;
    tick();
    bus.local_irq = 4'b0000;
    tick();
    bus.wr_mip = 1'b1; bus.mip_in = 32'h0;
    tick();
    bus.wr_mip = 1'b0;
    check("edge_setwins", bus.mip, 32'h0001_0000);
    bus.wr_mip = 1'b1; bus.mip_in = 32'h0001_0000;
    tick();
    check("edge_wr1_keep", bus.mip, 32'h0001_0000);
    bus.mip_in = 32'h0;
    tick();
    bus.wr_mip = 1'b0;
    check("edge_swclr", bus.mip, 32'h0);

    // Reset mid-handshake
    bus.mstatus_mie = 1'b1;
    bus.timer_irq = 1'b1;
    bus.wr_mie = 1'b1; bus.mie_in = 32'h80;
    tick();
    bus.wr_mie = 1'b0;
    tick(4);
    check("pre_rst_req", {31'd0, bus.trap_req}, 32'h1);
    rst = 1'b1;
    tick();
    check("mid_rst_req", {31'd0, bus.trap_req}, 32'h0);
    check("mid_rst_mie", bus.mie, 32'h0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
